// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame shape and default bit timing.
package uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_STOP_BITS    = 1;
   // 100 MHz system clock at 115200 baud.
   localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle between the serial pin / I/O unit and the UART receiver.
interface uart_receiver_if;
   import uart_pkg::*;

   logic                      rxd;
   logic                      rd_en;
   logic                      err_clr;
   logic [UART_DATA_BITS-1:0] data;
   logic                      rdy;
   logic                      frame_err;
   logic                      overrun;

   // Master drives the line and the pop/clear strobes; slave is the receiver.
   modport master (output rxd, rd_en, err_clr, input data, rdy, frame_err, overrun);
   modport slave  (input rxd, rd_en, err_clr, output data, rdy, frame_err, overrun);

endinterface

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO. Head entry is visible on pop_data while
// not empty; the output is forced to zero when empty so reset shows a clean bus.
module uart_rx_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              wr_go;
   logic              rd_go;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop frees a slot on the same edge, so a push into a full FIFO is taken
   // when it coincides with a pop. Pops of an empty FIFO are ignored.
   assign rd_go = pop && !empty;
   assign wr_go = push && (!full || pop);

   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (wr_go) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_go) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_go) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_go, rd_go})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: two-flop input synchroniser, mid-bit sampling FSM, a
// small FWFT byte FIFO and sticky frame-error / overrun flags.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     clk,
   input  logic     reset,
   uart_receiver_if.slave rx_if
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_BIT_RELOAD = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_BIT        = IDX_W'(UART_DATA_BITS - 1);

   logic                      rx_sync_p0;
   logic                      rx_sync_p1;
   logic                      rxs;

   rx_state_t                 state;
   rx_state_t                 state_n;
   logic [CNT_W-1:0]          cnt;
   logic [CNT_W-1:0]          cnt_n;
   logic [IDX_W-1:0]          bit_idx;
   logic [IDX_W-1:0]          bit_idx_n;
   logic [UART_DATA_BITS-1:0] shift;
   logic [UART_DATA_BITS-1:0] shift_n;
   logic                      byte_ok;
   logic                      frame_set;
   logic                      overrun_set;

   logic                      fifo_full;
   logic                      fifo_empty;

   logic                      frame_err_q;
   logic                      overrun_q;

   // Two-flop synchroniser; idles high like the line so reset never fakes a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx_if.rxd;
         rx_sync_p1 <= rx_sync_p0;
      end
   end

   assign rxs = rx_sync_p1;

   // FSM state, bit timer, bit index and shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
      end
   end

   // Next-state logic: half-bit delay to the start midpoint, then full-bit steps.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      byte_ok   = 1'b0;
      frame_set = 1'b0;
      case (state)
         RX_IDLE: begin
            if (!rxs) begin
               cnt_n   = HALF_BIT_RELOAD;
               state_n = RX_START;
            end
         end
         RX_START: begin
            if (cnt == '0) begin
               if (!rxs) begin
                  cnt_n     = FULL_BIT_RELOAD;
                  bit_idx_n = '0;
                  state_n   = RX_DATA;
               end else begin
                  // Line went back high before mid-bit: a glitch, not a frame.
                  state_n = RX_IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == '0) begin
               shift_n = {rxs, shift[UART_DATA_BITS-1:1]};
               cnt_n   = FULL_BIT_RELOAD;
               if (bit_idx == LAST_BIT) begin
                  state_n = RX_STOP;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == '0) begin
               byte_ok   = rxs;
               frame_set = !rxs;
               // Back to IDLE at the stop midpoint so an early next start is caught.
               state_n   = RX_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = RX_IDLE;
         end
      endcase
   end

   // A good byte is lost only when the FIFO is full and not being popped this edge.
   assign overrun_set = byte_ok && fifo_full && !rx_if.rd_en;

   uart_rx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (byte_ok),
      .push_data (shift),
      .pop       (rx_if.rd_en),
      .pop_data  (rx_if.data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sticky error flags; a set event on the same edge as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (frame_set) begin
            frame_err_q <= 1'b1;
         end else if (rx_if.err_clr) begin
            frame_err_q <= 1'b0;
         end
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end else if (rx_if.err_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign rx_if.rdy       = !fifo_empty;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver with a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   uart_receiver_if rif ();

   uart_receiver #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rx_if (rif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: bytes the receiver should be holding and the sticky flags.
   logic [7:0] q [$];
   logic       m_ferr;
   logic       m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model of one complete frame: optional pop on the push edge, then the byte.
   task automatic model_frame(input logic [7:0] b, input logic stop, input logic pop_at_push);
      if (pop_at_push && q.size() > 0) void'(q.pop_front());
      if (stop) begin
         if (q.size() < DEPTH) q.push_back(b);
         else m_ovr = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // Serialise one 8N1 frame. pop_at_push raises rd_en exactly on the stop
   // sampling edge; abort_k >= 0 hits reset at that cycle of the frame instead.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input logic pop_at_push, input int abort_k);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      @(posedge clk);
      #1;
      for (int k = 0; k < 10 * CPB; k++) begin
         rif.rxd = bits[k / CPB];
         if (pop_at_push && k == 154) rif.rd_en = 1'b1;
         if (k == 155) rif.rd_en = 1'b0;
         if (k == abort_k) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            rif.rxd = 1'b1;
            return;
         end
         tick(1);
      end
      rif.rxd = 1'b1;
      if (!stop) tick(20);
      model_frame(b, stop, pop_at_push);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp_b;
      exp_b = (q.size() > 0) ? q.pop_front() : 8'h00;
      check({tag, "_rdy"}, 32'(rif.rdy), 32'(1));
      check({tag, "_data"}, 32'(rif.data), 32'(exp_b));
      rif.rd_en = 1'b1;
      tick(1);
      rif.rd_en = 1'b0;
   endtask

   task automatic clear_flags();
      rif.err_clr = 1'b1;
      tick(1);
      rif.err_clr = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_rdy"}, 32'(rif.rdy), 32'(q.size() != 0));
      check({tag, "_ferr"}, 32'(rif.frame_err), 32'(m_ferr));
      check({tag, "_ovr"}, 32'(rif.overrun), 32'(m_ovr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rb;
      logic       rs;
      int         npop;

      reset       = 1'b1;
      rif.rxd     = 1'b1;
      rif.rd_en   = 1'b0;
      rif.err_clr = 1'b0;
      m_ferr      = 1'b0;
      m_ovr       = 1'b0;
      tick(3);
      check("rst_rdy", 32'(rif.rdy), 32'(0));
      check("rst_data", 32'(rif.data), 32'(0));
      check("rst_ferr", 32'(rif.frame_err), 32'(0));
      check("rst_ovr", 32'(rif.overrun), 32'(0));
      reset = 1'b0;
      tick(2);

      // Single frame, then pop.
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      tick(4 * CPB);
      check_state("single");
      pop_check("single_pop");
      check("single_empty", 32'(rif.rdy), 32'(0));

      // Short low pulse is rejected without a flag.
      rif.rxd = 1'b0;
      tick(4);
      rif.rxd = 1'b1;
      tick(2 * CPB);
      check("glitch_idle", 32'(dut.state), 32'(uart_pkg::RX_IDLE));
      check_state("glitch");
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      pop_check("glitch_next");

      // Stop bit low.
      send_frame(8'h55, 1'b0, 1'b0, -1);
      check_state("frame");
      check("frame_set", 32'(rif.frame_err), 32'(1));
      clear_flags();
      check("frame_clr", 32'(rif.frame_err), 32'(0));

      // Five frames back-to-back into a four-entry FIFO.
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
      check_state("ovr");
      check("ovr_set", 32'(rif.overrun), 32'(1));
      for (int i = 0; i < 4; i++) pop_check("ovr_pop");
      check("ovr_empty", 32'(rif.rdy), 32'(0));
      clear_flags();
      check("ovr_clr", 32'(rif.overrun), 32'(0));

      // Push and pop on the same edge while full.
      for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1, 1'b0, -1);
      send_frame(8'hEE, 1'b1, 1'b1, -1);
      check_state("pp");
      check("pp_count", 32'(dut.u_fifo.count), 32'(4));
      for (int i = 0; i < 4; i++) pop_check("pp_pop");
      check("pp_empty", 32'(rif.rdy), 32'(0));

      // Randomized frames with occasional bad stop bits, pops and clears.
      for (int n = 0; n < 10; n++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         send_frame(rb, rs, 1'b0, -1);
         check_state("rnd");
         npop = $urandom_range(0, q.size());
         for (int i = 0; i < npop; i++) pop_check("rnd_pop");
         if ($urandom_range(0, 2) == 0) clear_flags();
      end
      while (q.size() > 0) pop_check("rnd_drain");
      clear_flags();

      // Reset during data bit 3 with two bytes queued.
      send_frame(8'h11, 1'b1, 1'b0, -1);
      send_frame(8'h22, 1'b1, 1'b0, -1);
      check("mid_pre_rdy", 32'(rif.rdy), 32'(1));
      send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB + 6);
      q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      check("mid_idle", 32'(dut.state), 32'(uart_pkg::RX_IDLE));
      check("mid_data", 32'(rif.data), 32'(0));
      check_state("mid");
      tick(2 * CPB);
      send_frame(8'h81, 1'b1, 1'b0, -1);
      check_state("after_rst");
      pop_check("after_rst_pop");
      check("after_rst_empty", 32'(rif.rdy), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
